rd_tracker: RTL and testbench

- Parametrised multi-lane running-disparity (RD) tracker for 8b/10b 10-bit symbols in the PCIe physical receive path.
- Sits after the symbol aligner and before the 8b/10b decoder.
- Per lane it checks sub-block disparity against the running disparity, flags code and disparity errors, and keeps a lock state machine.
- Per lane it also maintains a saturating error counter for link-health monitoring.

---
 rtl/pcie_8b10b_pkg.sv | 114 +++++++++++
 rtl/rd_tracker_lane.sv | 114 +++++++++++
 rtl/rd_tracker.sv | 42 ++++
 tb/tb_rd_tracker.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/pcie_8b10b_pkg.sv
// Shared 8b/10b definitions for the receive-path disparity tracker:
// symbol geometry, lane lock states, sub-block classification helpers.
package pcie_8b10b_pkg;

    localparam int SYM_W = 10;
    localparam int SB6_W = 6;
    localparam int SB4_W = 4;

    // Balanced sub-blocks that still carry a disparity requirement.
    // Vectors are written with 'a' (6b) or 'f' (4b) as bit 0, so the
    // transmission-order pattern reads right-to-left.
    localparam logic [SB6_W-1:0] SB6_POS_END = 6'b111000;  // abcdei 000111
    localparam logic [SB6_W-1:0] SB6_NEG_END = 6'b000111;  // abcdei 111000
    localparam logic [SB4_W-1:0] SB4_POS_END = 4'b1100;    // fghj 0011
    localparam logic [SB4_W-1:0] SB4_NEG_END = 4'b0011;    // fghj 1100

    typedef enum logic {
        RD_ACQUIRE = 1'b0,
        RD_LOCKED  = 1'b1
    } rd_state_e;

    typedef enum logic [2:0] {
        SB_NEUTRAL,
        SB_POS,
        SB_NEG,
        SB_POS_END,
        SB_NEG_END,
        SB_INVALID
    } sb_kind_e;

    // Outcome of checking one sub-block against the incoming RD.
    typedef struct packed {
        logic code_err;  // illegal ones-count
        logic rd_err;    // disparity rule broken
        logic rd_out;    // RD after this sub-block (1 = positive)
        logic biased;    // legal sub-block that is not plain neutral
    } sb_result_t;

    function automatic logic [3:0] popcount(input logic [SYM_W-1:0] v);
        logic [3:0] cnt;
        cnt = 4'd0;
        for (int i = 0; i < SYM_W; i++) begin
            cnt = cnt + {3'b000, v[i]};
        end
        return cnt;
    endfunction

    function automatic sb_kind_e classify6(input logic [SB6_W-1:0] sb);
        sb_kind_e kind;
        case (popcount({4'b0000, sb}))
            4'd2:    kind = SB_NEG;
            4'd4:    kind = SB_POS;
            4'd3: begin
                if (sb == SB6_POS_END)      kind = SB_POS_END;
                else if (sb == SB6_NEG_END) kind = SB_NEG_END;
                else                        kind = SB_NEUTRAL;
            end
            default: kind = SB_INVALID;
        endcase
        return kind;
    endfunction

    function automatic sb_kind_e classify4(input logic [SB4_W-1:0] sb);
        sb_kind_e kind;
        case (popcount({6'b000000, sb}))
            4'd1:    kind = SB_NEG;
            4'd3:    kind = SB_POS;
            4'd2: begin
                if (sb == SB4_POS_END)      kind = SB_POS_END;
                else if (sb == SB4_NEG_END) kind = SB_NEG_END;
                else                        kind = SB_NEUTRAL;
            end
            default: kind = SB_INVALID;
        endcase
        return kind;
    endfunction

    // RD always resyncs to the sub-block's ending disparity; an invalid
    // sub-block has no defined disparity and leaves RD untouched.
    function automatic sb_result_t check_sb(input sb_kind_e kind, input logic rd_in);
        sb_result_t res;
        res.code_err = 1'b0;
        res.rd_err   = 1'b0;
        res.rd_out   = rd_in;
        res.biased   = 1'b1;
        case (kind)
            SB_POS: begin
                res.rd_err = rd_in;
                res.rd_out = 1'b1;
            end
            SB_NEG: begin
                res.rd_err = ~rd_in;
                res.rd_out = 1'b0;
            end
            SB_POS_END: begin
                res.rd_err = ~rd_in;
                res.rd_out = 1'b1;
            end
            SB_NEG_END: begin
                res.rd_err = rd_in;
                res.rd_out = 1'b0;
            end
            SB_NEUTRAL: begin
                res.biased = 1'b0;
            end
            default: begin
                res.code_err = 1'b1;
                res.biased   = 1'b0;
            end
        endcase
        return res;
    endfunction

endpackage

// File: rtl/rd_tracker_lane.sv
// One lane of the running-disparity tracker: sub-block classification,
// RD register, ACQUIRE/LOCKED state machine and error counters.
module rd_tracker_lane
    import pcie_8b10b_pkg::*;
#(
    parameter int ERR_CNT_W   = 8,
    parameter int LOSS_THRESH = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 valid_i,
    input  logic [SYM_W-1:0]     symbol_i,
    input  logic                 err_clr_i,
    output logic                 valid_o,
    output logic                 rd_o,
    output logic                 code_err_o,
    output logic                 rd_err_o,
    output logic                 locked_o,
    output logic [ERR_CNT_W-1:0] err_cnt_o
);

    localparam logic [3:0] LOSS_LIMIT = 4'(LOSS_THRESH);

    rd_state_e            state_q, state_d;
    logic                 rd_q, rd_d;
    logic [3:0]           run_q, run_d;
    logic [ERR_CNT_W-1:0] cnt_q, cnt_d;
    logic                 valid_q, code_err_q, rd_err_q;

    sb_result_t res6, res4;
    logic       code_err, rd_err, sym_bad;

    // Classify both sub-blocks; the 6b ending RD is the 4b incoming RD.
    always_comb begin
        res6     = check_sb(classify6(symbol_i[SB6_W-1:0]), rd_q);
        res4     = check_sb(classify4(symbol_i[SYM_W-1:SB6_W]), res6.rd_out);
        code_err = res6.code_err | res4.code_err;
        rd_err   = (res6.rd_err | res4.rd_err) & (state_q == RD_LOCKED);
        sym_bad  = valid_i & (code_err | rd_err);
    end

    // Next RD, lock state and consecutive-error run for an accepted symbol.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first,
        // otherwise paths that skip an assignment infer a latch.
        rd_d    = rd_q;
        state_d = state_q;
        run_d   = run_q;
        if (valid_i) begin
            rd_d = res4.rd_out;
            case (state_q)
                RD_ACQUIRE: begin
                    if (!code_err && (res6.biased || res4.biased)) begin
                        state_d = RD_LOCKED;
                        run_d   = 4'd0;
                    end
                end
                default: begin
                    if (sym_bad) begin
                        if (run_q + 4'd1 >= LOSS_LIMIT) begin
                            state_d = RD_ACQUIRE;
                            run_d   = 4'd0;
                        end else begin
                            run_d = run_q + 4'd1;
                        end
                    end else begin
                        run_d = 4'd0;
                    end
                end
            endcase
        end
    end

    // Saturating link-health counter; a clear wins over a same-cycle error.
    always_comb begin
        cnt_d = cnt_q;
        if (err_clr_i) begin
            cnt_d = '0;
        end else if (sym_bad && (cnt_q != '1)) begin
            cnt_d = cnt_q + ERR_CNT_W'(1);
        end
    end

    // Lane state and per-symbol output registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values regardless of statement order.
        if (!rst_ni) begin
            state_q    <= RD_ACQUIRE;
            rd_q       <= 1'b0;
            run_q      <= 4'd0;
            cnt_q      <= '0;
            valid_q    <= 1'b0;
            code_err_q <= 1'b0;
            rd_err_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            rd_q       <= rd_d;
            run_q      <= run_d;
            cnt_q      <= cnt_d;
            valid_q    <= valid_i;
            code_err_q <= valid_i & code_err;
            rd_err_q   <= valid_i & rd_err;
        end
    end

    assign valid_o    = valid_q;
    assign rd_o       = rd_q;
    assign code_err_o = code_err_q;
    assign rd_err_o   = rd_err_q;
    assign locked_o   = (state_q == RD_LOCKED);
    assign err_cnt_o  = cnt_q;

endmodule

// File: rtl/rd_tracker.sv
// Multi-lane running-disparity tracker placed between the symbol aligner
// and the 8b/10b decoder. Lanes are independent; this level only slices buses.
module rd_tracker
    import pcie_8b10b_pkg::*;
#(
    parameter int NUM_LANES   = 4,
    parameter int ERR_CNT_W   = 8,
    parameter int LOSS_THRESH = 4
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic [NUM_LANES-1:0]           valid_i,
    input  logic [NUM_LANES*SYM_W-1:0]     symbol_i,
    input  logic [NUM_LANES-1:0]           err_clr_i,
    output logic [NUM_LANES-1:0]           valid_o,
    output logic [NUM_LANES-1:0]           rd_o,
    output logic [NUM_LANES-1:0]           code_err_o,
    output logic [NUM_LANES-1:0]           rd_err_o,
    output logic [NUM_LANES-1:0]           locked_o,
    output logic [NUM_LANES*ERR_CNT_W-1:0] err_cnt_o
);

    for (genvar n = 0; n < NUM_LANES; n++) begin : g_lane
        rd_tracker_lane #(
            .ERR_CNT_W  (ERR_CNT_W),
            .LOSS_THRESH(LOSS_THRESH)
        ) u_lane (
            .clk_i     (clk_i),
            .rst_ni    (rst_ni),
            .valid_i   (valid_i[n]),
            .symbol_i  (symbol_i[n*SYM_W +: SYM_W]),
            .err_clr_i (err_clr_i[n]),
            .valid_o   (valid_o[n]),
            .rd_o      (rd_o[n]),
            .code_err_o(code_err_o[n]),
            .rd_err_o  (rd_err_o[n]),
            .locked_o  (locked_o[n]),
            .err_cnt_o (err_cnt_o[n*ERR_CNT_W +: ERR_CNT_W])
        );
    end

endmodule

// File: tb/tb_rd_tracker.sv
// Randomised self-checking bench for rd_tracker against a disparity model
// built from ones-counts and signed running disparity.
module tb_rd_tracker;

    localparam int NL  = 4;
    localparam int CW  = 8;
    localparam int LT  = 4;
    localparam int MAX = (1 << CW) - 1;

    logic              clk_i = 1'b0;
    logic              rst_ni;
    logic [NL-1:0]     valid_i;
    logic [NL*10-1:0]  symbol_i;
    logic [NL-1:0]     err_clr_i;
    logic [NL-1:0]     valid_o, rd_o, code_err_o, rd_err_o, locked_o;
    logic [NL*CW-1:0]  err_cnt_o;

    rd_tracker #(.NUM_LANES(NL), .ERR_CNT_W(CW), .LOSS_THRESH(LT)) dut (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .valid_i   (valid_i),
        .symbol_i  (symbol_i),
        .err_clr_i (err_clr_i),
        .valid_o   (valid_o),
        .rd_o      (rd_o),
        .code_err_o(code_err_o),
        .rd_err_o  (rd_err_o),
        .locked_o  (locked_o),
        .err_cnt_o (err_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;

    // Reference state: RD as +1/-1, lock flag, run of bad symbols, error count.
    int m_rd   [NL];
    bit m_lock [NL];
    int m_run  [NL];
    int m_cnt  [NL];
    bit e_valid[NL];
    bit e_code [NL];
    bit e_rderr[NL];

    logic [9:0] sym_table [8] = '{10'h17C, 10'h283, 10'h2AA, 10'h0B9,
                                  10'h338, 10'h0C7, 10'h155, 10'h2C3};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic void model_reset();
        for (int l = 0; l < NL; l++) begin
            m_rd[l] = -1; m_lock[l] = 0; m_run[l] = 0; m_cnt[l] = 0;
            e_valid[l] = 0; e_code[l] = 0; e_rderr[l] = 0;
        end
    endfunction

    // One sub-block of width w, v[0] transmitted first. Balanced blocks whose
    // first half is all zeros end positive; all ones end negative.
    function automatic void eval_sb(input int w, input logic [5:0] v, input int rd_in,
                                    output bit code, output bit derr,
                                    output int rd_out, output bit biased);
        int ones = 0, head = 0, disp;
        for (int i = 0; i < w; i++) begin
            ones += int'(v[i]);
            if (i < w / 2) head += int'(v[i]);
        end
        disp = 2 * ones - w;
        code = 0; derr = 0; rd_out = rd_in; biased = 1;
        if (disp > 2 || disp < -2) begin
            code = 1; biased = 0;
        end else if (disp == 2) begin
            derr = (rd_in > 0); rd_out = 1;
        end else if (disp == -2) begin
            derr = (rd_in < 0); rd_out = -1;
        end else if (head == 0) begin
            derr = (rd_in < 0); rd_out = 1;
        end else if (head == w / 2) begin
            derr = (rd_in > 0); rd_out = -1;
        end else begin
            biased = 0;
        end
    endfunction

    function automatic void model_lane(input int l, input bit v, input logic [9:0] s, input bit clr);
        bit c6, d6, b6, c4, d4, b4, code, rderr, bad;
        int r6, r4;
        eval_sb(6, s[5:0], m_rd[l], c6, d6, r6, b6);
        eval_sb(4, {2'b00, s[9:6]}, r6, c4, d4, r4, b4);
        code  = c6 | c4;
        rderr = m_lock[l] & (d6 | d4);
        bad   = v & (code | rderr);
        e_valid[l] = v;
        e_code[l]  = v & code;
        e_rderr[l] = v & rderr;
        if (clr) m_cnt[l] = 0;
        else if (bad && m_cnt[l] < MAX) m_cnt[l]++;
        if (v) begin
            m_rd[l] = r4;
            if (!m_lock[l]) begin
                if (!code && (b6 || b4)) begin m_lock[l] = 1; m_run[l] = 0; end
            end else if (bad) begin
                m_run[l]++;
                if (m_run[l] >= LT) begin m_lock[l] = 0; m_run[l] = 0; end
            end else begin
                m_run[l] = 0;
            end
        end
    endfunction

    function automatic logic [9:0] rand_sym();
        if ($urandom_range(0, 3) == 0) return 10'($urandom);
        return sym_table[$urandom_range(0, 7)];
    endfunction

    task automatic compare_all(input string tag);
        for (int l = 0; l < NL; l++) begin
            check($sformatf("%s valid l%0d", tag, l), valid_o[l], e_valid[l]);
            check($sformatf("%s rd l%0d", tag, l), rd_o[l], m_rd[l] > 0);
            check($sformatf("%s code l%0d", tag, l), code_err_o[l], e_code[l]);
            check($sformatf("%s rderr l%0d", tag, l), rd_err_o[l], e_rderr[l]);
            check($sformatf("%s lock l%0d", tag, l), locked_o[l], m_lock[l]);
            check($sformatf("%s cnt l%0d", tag, l), err_cnt_o[l*CW +: CW], m_cnt[l]);
        end
    endtask

    // Drive one cycle at the falling edge, sample one tick after the rising edge.
    // Lane 0 takes the given values; the other lanes get random traffic.
    task automatic step(input string tag, input bit v0, input logic [9:0] s0, input bit clr0,
                        input bit rand_all);
        logic [NL-1:0]    v, c;
        logic [NL*10-1:0] s;
        @(negedge clk_i);
        for (int l = 0; l < NL; l++) begin
            v[l] = ($urandom_range(0, 3) != 0);
            s[l*10 +: 10] = rand_sym();
            c[l] = ($urandom_range(0, 31) == 0);
        end
        if (!rand_all) begin
            v[0] = v0; s[9:0] = s0; c[0] = clr0;
        end
        valid_i = v; symbol_i = s; err_clr_i = c;
        for (int l = 0; l < NL; l++) model_lane(l, v[l], s[l*10 +: 10], c[l]);
        @(posedge clk_i);
        #1;
        compare_all(tag);
    endtask

    task automatic check_zero(input string tag);
        check({tag, " valid"}, valid_o, '0);
        check({tag, " rd"}, rd_o, '0);
        check({tag, " code"}, code_err_o, '0);
        check({tag, " rderr"}, rd_err_o, '0);
        check({tag, " lock"}, locked_o, '0);
        check({tag, " cnt"}, err_cnt_o, '0);
    endtask

    initial begin
        rst_ni = 1'b0; valid_i = '0; symbol_i = '0; err_clr_i = '0;
        model_reset();
        repeat (3) @(posedge clk_i);
        #1 check_zero("reset");
        @(negedge clk_i) rst_ni = 1'b1;

        // Lock on K28.5 from RD-, then alternate disparity cleanly.
        step("k28_first", 1'b1, 10'h17C, 1'b0, 1'b0);
        check("tp_lock", locked_o[0], 1);
        check("tp_rd_pos", rd_o[0], 1);
        step("k28_alt1", 1'b1, 10'h283, 1'b0, 1'b0);
        check("tp_rd_neg", rd_o[0], 0);
        step("k28_alt2", 1'b1, 10'h17C, 1'b0, 1'b0);
        check("tp_rd_pos2", rd_o[0], 1);
        check("tp_cnt0", err_cnt_o[CW-1:0], 0);

        // Wrong-disparity symbol while locked at RD+.
        step("rd_violate", 1'b1, 10'h17C, 1'b0, 1'b0);
        check("tp_rderr", rd_err_o[0], 1);
        check("tp_rd_stay", rd_o[0], 1);
        check("tp_cnt1", err_cnt_o[CW-1:0], 1);
        check("tp_still_lock", locked_o[0], 1);

        // Clean symbol ends the error run, idle cycle clears the counter.
        step("clean", 1'b1, 10'h283, 1'b0, 1'b0);
        step("idle_clr", 1'b0, 10'h000, 1'b1, 1'b0);
        check("tp_idle_valid", valid_o[0], 0);

        // Loss of lock after LT consecutive code errors.
        for (int i = 0; i < LT; i++) begin
            step("loss", 1'b1, 10'h000, 1'b0, 1'b0);
            check("tp_loss_code", code_err_o[0], 1);
            check("tp_loss_lock", locked_o[0], i < LT - 1);
        end
        check("tp_loss_cnt", err_cnt_o[CW-1:0], LT);

        // Counter saturation, then clear beating a same-cycle error.
        for (int i = 0; i < MAX + 4; i++) step("sat", 1'b1, 10'h000, 1'b0, 1'b0);
        check("tp_sat", err_cnt_o[CW-1:0], MAX);
        step("sat_more", 1'b1, 10'h3FF, 1'b0, 1'b0);
        check("tp_sat_hold", err_cnt_o[CW-1:0], MAX);
        step("clr_prio", 1'b1, 10'h000, 1'b1, 1'b0);
        check("tp_clr_prio", err_cnt_o[CW-1:0], 0);

        // Independent random traffic on every lane.
        for (int i = 0; i < 400; i++) step("rand", 1'b0, 10'h000, 1'b0, 1'b1);

        // Asynchronous reset mid-stream: outputs clear before any clock edge.
        @(negedge clk_i);
        #2 rst_ni = 1'b0;
        #1 check_zero("async_rst");
        model_reset();
        valid_i = '0; err_clr_i = '0;
        @(negedge clk_i) rst_ni = 1'b1;

        for (int i = 0; i < 300; i++) step("rand2", 1'b0, 10'h000, 1'b0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
